// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC-holding instruction fetch sequencer. Owns the architectural
//               PC, issues one instruction-memory request at a time, and hands
//               fetched instructions (tagged with their PC) to decode over a
//               valid/ready handshake. A redirect flushes the in-flight path.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous active-high reset
//   next_pc         in  32   successor of cur_pc (from program_counter)
//   cur_pc          out 32   architectural PC register
//   redirect_valid  in   1   flush request from execute
//   redirect_pc     in  32   redirect target
//   imem_req_valid  out  1   fetch request valid
//   imem_req_addr   out 32   fetch address (== cur_pc)
//   imem_req_ready  in   1   memory accepts request
//   imem_rsp_valid  in   1   response strobe (no backpressure)
//   imem_rsp_data   in  32   instruction word
//   inst_valid      out  1   decode output valid
//   inst_data       out 32   fetched instruction
//   inst_pc         out 32   PC of inst_data
//   inst_ready      in   1   decode accepts
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] cur_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing a request, output register empty
    S_WAIT = 2'd1,  // one request outstanding
    S_HOLD = 2'd2   // output register full
  } state_t;

  state_t      r_state;
  logic        r_kill;
  logic [31:0] r_pc;
  logic        r_inst_valid;
  logic [31:0] r_inst_data;
  logic [31:0] r_inst_pc;

  state_t      w_state_n;
  logic        w_kill_n;
  logic [31:0] w_pc_n;
  logic        w_inst_valid_n;
  logic [31:0] w_inst_data_n;
  logic [31:0] w_inst_pc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_kill       <= 1'b0;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_data  <= 32'h0;
      r_inst_pc    <= 32'h0;
    end else begin
      r_state      <= w_state_n;
      r_kill       <= w_kill_n;
      r_pc         <= w_pc_n;
      r_inst_valid <= w_inst_valid_n;
      r_inst_data  <= w_inst_data_n;
      r_inst_pc    <= w_inst_pc_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_kill_n       = r_kill;
    w_pc_n         = r_pc;
    w_inst_valid_n = r_inst_valid;
    w_inst_data_n  = r_inst_data;
    w_inst_pc_n    = r_inst_pc;

    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_n         = redirect_pc;
          w_inst_valid_n = 1'b0;
          // A request accepted this cycle still carries the old address, so
          // its response must be thrown away when it returns.
          if (imem_req_ready) begin
            w_state_n = S_WAIT;
            w_kill_n  = 1'b1;
          end
        end else if (imem_req_ready) begin
          w_state_n = S_WAIT;
          w_kill_n  = 1'b0;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_n         = redirect_pc;
          w_inst_valid_n = 1'b0;
          if (imem_rsp_valid) begin
            w_state_n = S_REQ;
            w_kill_n  = 1'b0;
          end else begin
            w_kill_n  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_kill) begin
            // cur_pc already holds the redirect target; just re-issue.
            w_state_n = S_REQ;
            w_kill_n  = 1'b0;
          end else begin
            w_inst_data_n  = imem_rsp_data;
            w_inst_pc_n    = r_pc;
            w_inst_valid_n = 1'b1;
            w_pc_n         = next_pc;
            w_state_n      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_n         = redirect_pc;
          w_inst_valid_n = 1'b0;
          w_state_n      = S_REQ;
        end else if (inst_ready) begin
          // Going through the state register keeps inst_ready off the
          // combinational path to imem_req_valid.
          w_inst_valid_n = 1'b0;
          w_state_n      = S_REQ;
        end
      end

      default: begin
        w_state_n = S_REQ;
        w_kill_n  = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = (r_state == S_REQ) && !rst;
  assign imem_req_addr  = r_pc;
  assign cur_pc         = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. The stimulus process pushes
//               the expected (pc, data) of every instruction that must reach
//               decode; a monitor pops and compares on each decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic [31:0] cur_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;
  int rsp_lat  = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .cur_pc         (cur_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program_counter model: sequential successor
  assign next_pc = cur_pc + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    sb.push_back(e);
  endtask

  // Memory model: word at address A is {16'hC0DE, A[15:0]}; response arrives
  // rsp_lat cycles after acceptance, held for exactly one cycle.
  initial begin : mem_model
    logic        acc;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready && !rst;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      if (acc) begin
        repeat (rsp_lat - 1) begin
          @(posedge clk);
          #1;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = {16'hC0DE, a[15:0]};
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Decode-side monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst actual_pc=0x%08h actual_data=0x%08h expected=none",
                   inst_pc, inst_data);
        end else begin
          e = sb.pop_front();
          chk("deliv_pc", inst_pc, e.pc);
          chk("deliv_data", inst_data, e.data);
        end
      end
    end
  end

  initial begin : stim
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset
    repeat (3) step;
    smp;
    chk("rst_cur_pc", cur_pc, 32'h100);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);

    push(32'h100, 32'hC0DE_0100);
    push(32'h104, 32'hC0DE_0104);
    push(32'h108, 32'hC0DE_0108);

    // c0: first request right after release
    step; rst = 1'b0; smp;
    chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    step; smp;                                   // c1 WAIT
    chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    step; smp;                                   // c2 HOLD
    chk("lat_inst_valid", {31'h0, inst_valid}, 32'h1);
    step; smp;                                   // c3 REQ
    chk("seq_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("seq_req_addr1", imem_req_addr, 32'h104);
    step; step; step; smp;                       // c6 REQ
    chk("seq_req_addr2", imem_req_addr, 32'h108);

    // Decode stall in HOLD
    step; inst_ready = 1'b0;                     // c7 WAIT
    for (int i = 0; i < 5; i++) begin            // c8..c12 HOLD
      step; smp;
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_pc", inst_pc, 32'h108);
      chk("stall_data", inst_data, 32'hC0DE_0108);
      chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    step; inst_ready = 1'b1; rsp_lat = 3; smp;   // c13 handshake
    chk("hs_no_req", {31'h0, imem_req_valid}, 32'h0);
    step; smp;                                   // c14 REQ
    chk("post_stall_req", {31'h0, imem_req_valid}, 32'h1);
    chk("post_stall_addr", imem_req_addr, 32'h10C);

    // Redirect in WAIT, two cycles before the response
    step; redirect_valid = 1'b1; redirect_pc = 32'h200;   // c15
    push(32'h200, 32'hC0DE_0200);
    step; redirect_valid = 1'b0; rsp_lat = 1; smp;         // c16
    chk("rdw_cur_pc", cur_pc, 32'h200);
    chk("rdw_no_req", {31'h0, imem_req_valid}, 32'h0);
    chk("rdw_inst_valid", {31'h0, inst_valid}, 32'h0);
    step; smp;                                             // c17 killed rsp
    chk("rdw_kill_no_req", {31'h0, imem_req_valid}, 32'h0);
    step; smp;                                             // c18
    chk("rdw_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rdw_req_addr", imem_req_addr, 32'h200);
    step; step; step; smp;                                 // c21
    chk("rdw_next_addr", imem_req_addr, 32'h204);

    // Redirect in the same cycle as the response
    step; redirect_valid = 1'b1; redirect_pc = 32'h200;   // c22
    step; redirect_valid = 1'b0; smp;                      // c23
    chk("rds_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rds_req_addr", imem_req_addr, 32'h200);
    chk("rds_inst_valid", {31'h0, inst_valid}, 32'h0);

    // Redirect in HOLD (instruction 0x200 held, not accepted, discarded)
    step; inst_ready = 1'b0;                               // c24
    step; redirect_valid = 1'b1; redirect_pc = 32'h300; smp;   // c25
    chk("rdh_held_valid", {31'h0, inst_valid}, 32'h1);
    chk("rdh_held_pc", inst_pc, 32'h200);
    step; redirect_valid = 1'b0; inst_ready = 1'b1; smp;   // c26
    push(32'h300, 32'hC0DE_0300);
    chk("rdh_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rdh_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rdh_req_addr", imem_req_addr, 32'h300);
    step; step; step;                                      // c29

    // Redirect in REQ while the request is accepted
    redirect_valid = 1'b1; redirect_pc = 32'h300; smp;
    chk("rdr_old_addr", imem_req_addr, 32'h304);
    step; redirect_valid = 1'b0; smp;                      // c30 killed rsp
    push(32'h300, 32'hC0DE_0300);
    chk("rdr_no_req", {31'h0, imem_req_valid}, 32'h0);
    chk("rdr_cur_pc", cur_pc, 32'h300);
    step; smp;                                             // c31
    chk("rdr_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rdr_req_addr", imem_req_addr, 32'h300);
    step; step; step;                                      // c34

    // Redirect in REQ while the request is not accepted
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
    step; redirect_valid = 1'b0; imem_req_ready = 1'b1; smp;   // c35
    push(32'h500, 32'hC0DE_0500);
    chk("rdn_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rdn_req_addr", imem_req_addr, 32'h500);

    repeat (4) step;
    smp;
    chk("sb_empty", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

PC-holding instruction fetch sequencer. It keeps the architectural PC register and presents it on `cur_pc` to `program_counter`. It takes `program_counter`'s combinational `next_pc` back as the PC to use after each completed fetch. It issues one instruction-memory request at a time and delivers fetched instructions, tagged with their PC, to decode over a valid/ready handshake, with redirect (branch/exception) flush.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `next_pc`  in  32  from `program_counter`; successor of `cur_pc`.
- `cur_pc`  out  32  PC register; drives `program_counter.cur_pc`.
- `redirect_valid`  in  1  flush request from execute.
- `redirect_pc`  in  32  target PC when `redirect_valid`=1.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address; always equals `cur_pc`.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response strobe; there is no response backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  decode output valid.
- `inst_data`  out  32  fetched instruction.
- `inst_pc`  out  32  PC of `inst_data`.
- `inst_ready`  in  1  decode accepts.

## Operation

- FSM states:
  - REQ: issuing a request; the output register is empty.
  - WAIT: one request is outstanding.
  - HOLD: the output register is full.
- Flag `kill`: the outstanding response belongs to a flushed path.
- At most one request is outstanding. A request is only issued when the output register is empty, so a response always lands in a free slot.
- `imem_req_valid` = (state==REQ) && !rst.
- `imem_req_addr` = `cur_pc`.
- REQ transitions:
  - On `imem_req_ready`: go to WAIT, `kill`<=0.
- WAIT transitions:
  - On `imem_rsp_valid` with `kill`=0: `inst_data`<=`imem_rsp_data`, `inst_pc`<=`cur_pc`, `inst_valid`<=1, `cur_pc`<=`next_pc`, go to HOLD.
  - On `imem_rsp_valid` with `kill`=1: drop the response, `kill`<=0, go to REQ. `cur_pc` already holds the redirect target.
- HOLD transitions:
  - On `inst_ready`: `inst_valid`<=0, go to REQ on the next cycle. There is no combinational path from `inst_ready` to `imem_req_valid`.
- Redirect has priority over every other event. In all states `cur_pc`<=`redirect_pc` and `inst_valid`<=0.
  - REQ, not accepted this cycle: stay in REQ. The address changes to the target next cycle. Address change on redirect is the one permitted exception to request stability.
  - REQ, accepted this cycle: the request at the old address is in flight. Go to WAIT with `kill`<=1.
  - WAIT, no response this cycle: stay in WAIT, `kill`<=1.
  - WAIT, response this cycle: drop the response, go to REQ.
  - HOLD: discard the held instruction, go to REQ. If `inst_ready`=1 the same cycle, that handshake counts as delivered; decode discards it.
- `next_pc` is sampled only on a non-killed response. Between responses, `program_counter` output is ignored.
- `rst` clears the FSM and `kill`. The memory shares `rst` and returns no response for a request issued before reset.

## Timing

- Reset values: state=REQ, `cur_pc`=`RESET_PC`, `kill`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0.
- Outputs while `rst`=1: `imem_req_valid`=0.
- First request: `imem_req_valid`=1 in the first cycle after `rst` deasserts.
- Reset mid-WAIT or mid-HOLD: the next edge with `rst`=1 forces the reset values. The held instruction is lost.
- Latency, with zero-wait memory (ready=1, response the cycle after acceptance) and `inst_ready`=1:
  - Cycle 0: request accepted.
  - Cycle 1: response.
  - Cycle 2: `inst_valid`=1 and the instruction is accepted.
  - Cycle 3: next request.
  - Throughput: one instruction per 3 cycles.
- Redirect cycle n: the target appears on `imem_req_addr` in cycle n+1 if the FSM is in REQ, otherwise once the killed response returns. `inst_valid`=0 from cycle n+1.
- While `inst_valid`=1 and `inst_ready`=0, `inst_data` and `inst_pc` are stable.
- All outputs are registered except `imem_req_valid` and `imem_req_addr`, which are state/PC decodes.

## Test plan

- Reset, `RESET_PC`=0x100 -> `cur_pc`=0x100; `imem_req_valid`=0 during `rst`; `imem_req_valid`=1 with addr 0x100 in the first cycle after release.
- Sequential fetch, bench models `next_pc`=`cur_pc`+4, zero-wait memory, `inst_ready`=1 -> `inst_pc` sequence 0x100, 0x104, 0x108 with matching data, one instruction per 3 cycles.
- `inst_ready`=0 for 5 cycles while in HOLD -> `inst_valid`, `inst_data` and `inst_pc` stable; no request issued; request issued the cycle after `inst_ready` rises.
- Redirect to 0x200 in WAIT, 2 cycles before the response -> response dropped; no `inst_valid` for the old PC; next request addr 0x200; first delivered `inst_pc`=0x200.
- Redirect to 0x200 in the same cycle as `imem_rsp_valid` -> response dropped; REQ addr 0x200 next cycle.
- Redirect to 0x300 in HOLD, and separately redirect in REQ with `imem_req_ready`=1 -> HOLD case: `inst_valid` cleared next cycle, next request 0x300. REQ case: old request's response dropped, then request 0x300.
